// File: rtl/uart_mmio_ctrl_pkg.sv
// Shared constants for the memory-mapped UART controller: register offsets,
// status/interrupt bit positions, reset values and TX drain FSM states.
package uart_mmio_ctrl_pkg;

  localparam int OFF_UBRR = 0;
  localparam int OFF_UCSZ = 1;
  localparam int OFF_UCR  = 2;
  localparam int OFF_UDR  = 3;
  localparam int OFF_USR  = 4;
  localparam int OFF_IER  = 5;

  localparam int USR_TX_NFULL  = 0;
  localparam int USR_RX_NEMPTY = 1;
  localparam int USR_TX_IDLE   = 2;
  localparam int USR_OVERRUN   = 3;

  localparam int IER_RX  = 0;
  localparam int IER_TX  = 1;
  localparam int IER_OVR = 2;

  localparam logic [3:0] UCSZ_RST = 4'd8;
  localparam logic [1:0] UCR_RST  = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD      = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } tx_state_t;

  // Word address of a register, truncated to the bus width.
  function automatic logic [31:0] reg_addr(input logic [31:0] base, input int offset);
    return base + 32'(offset);
  endfunction

endpackage

// File: rtl/uart_mmio_ctrl_if.sv
// CPU data-bus view of the UART controller: address, strobes, data and the
// stall handshake that freezes the CPU while a TX push cannot be taken.
interface uart_mmio_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] addr;
  logic              re;
  logic              we;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              stall;

  modport master (output addr, re, we, wdata, input rdata, stall);
  modport slave  (input addr, re, we, wdata, output rdata, stall);
endinterface

// File: rtl/uart_mmio_ctrl_sync_fifo.sv
// Single-clock FIFO with power-of-two depth; pointers wrap naturally and the
// occupancy count is one bit wider than the pointers. Push while full is
// accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/uart_mmio_ctrl.sv
// Memory-mapped UART controller: register decode, TX/RX FIFOs and TX drain FSM.
// Optional interrupt logic is built when UART_MMIO_IRQ_EN is defined.
module uart_mmio_ctrl
  import uart_mmio_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h40,
  parameter int          ADDR_W    = 32,
  parameter int          TX_DEPTH  = 8,
  parameter int          RX_DEPTH  = 8,
  parameter logic [11:0] UBRR_RST  = 12'd103
) (
  input  logic             clk,
  input  logic             rst,
  uart_mmio_ctrl_if.slave  bus,
  output logic [11:0]      ubrr,
  output logic [3:0]       ucsz,
  output logic [1:0]       ucr,
  output logic [7:0]       tx_data,
  output logic             tx_start,
  input  logic             tx_busy,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             irq
);
  localparam int TX_CW = $clog2(TX_DEPTH) + 1;
  localparam int RX_CW = $clog2(RX_DEPTH) + 1;

  logic [ADDR_W-1:0] off;
  logic sel_ubrr, sel_ucsz, sel_ucr, sel_udr, sel_usr, sel_ier;
  logic stall_i, wr_en;
  logic overrun;
  logic [2:0] ier;

  logic             tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]       tx_head;
  logic [TX_CW-1:0] tx_count;
  logic             rx_push, rx_pop, rx_full, rx_empty, rx_take, ovr_set;
  logic [7:0]       rx_head;
  logic [RX_CW-1:0] rx_count;

  tx_state_t  state, state_nxt;
  logic [1:0] wait_cnt;
  logic       tx_idle;
  logic [31:0] usr;
  logic [31:0] rdata_i;
  logic        unused_bits;

  assign off      = bus.addr - ADDR_W'(BASE_ADDR);
  assign sel_ubrr = (off == ADDR_W'(OFF_UBRR));
  assign sel_ucsz = (off == ADDR_W'(OFF_UCSZ));
  assign sel_ucr  = (off == ADDR_W'(OFF_UCR));
  assign sel_udr  = (off == ADDR_W'(OFF_UDR));
  assign sel_usr  = (off == ADDR_W'(OFF_USR));
  assign sel_ier  = (off == ADDR_W'(OFF_IER));

  // A UDR write into a full TX FIFO freezes the CPU until the FSM frees a slot.
  assign stall_i   = bus.we && sel_udr && tx_full;
  assign bus.stall = stall_i;
  assign wr_en     = bus.we && !stall_i;

  assign tx_push = bus.we && sel_udr && !tx_full;
  assign rx_pop  = bus.re && sel_udr && !rx_empty && !stall_i;
  assign rx_take = ucr[1] && rx_valid;
  assign rx_push = rx_take && (!rx_full || rx_pop);
  assign ovr_set = rx_take && rx_full && !rx_pop;

  assign unused_bits = ^bus.wdata[31:12];

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .din(bus.wdata[7:0]),
    .dout(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .din(rx_data),
    .dout(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  // Overrun set wins over a same-cycle software clear so no drop goes unseen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ubrr    <= UBRR_RST;
      ucsz    <= UCSZ_RST;
      ucr     <= UCR_RST;
      overrun <= 1'b0;
    end else begin
      if (wr_en && sel_ubrr) ubrr <= bus.wdata[11:0];
      if (wr_en && sel_ucsz) ucsz <= bus.wdata[3:0];
      if (wr_en && sel_ucr)  ucr  <= bus.wdata[1:0];
      if (ovr_set)
        overrun <= 1'b1;
      else if (wr_en && sel_usr && bus.wdata[USR_OVERRUN])
        overrun <= 1'b0;
    end
  end

`ifdef UART_MMIO_IRQ_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ier <= 3'b000;
      irq <= 1'b0;
    end else begin
      if (wr_en && sel_ier) ier <= bus.wdata[2:0];
      irq <= (ier[IER_RX] & ~rx_empty) | (ier[IER_TX] & tx_empty) | (ier[IER_OVR] & overrun);
    end
  end
`else
  assign ier = 3'b000;
  assign irq = 1'b0;
`endif

  // tx_start is registered so it rises together with the freshly loaded tx_data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      wait_cnt <= 2'd0;
      tx_data  <= 8'h00;
      tx_start <= 1'b0;
    end else begin
      state    <= state_nxt;
      tx_start <= (state == ST_LOAD);
      if (state == ST_LOAD) tx_data <= tx_head;
      wait_cnt <= (state == ST_WAIT_BUSY) ? wait_cnt + 2'd1 : 2'd0;
    end
  end

  always_comb begin
    state_nxt = state;
    tx_pop    = 1'b0;
    case (state)
      ST_IDLE:      if (ucr[0] && !tx_empty && !tx_busy) state_nxt = ST_LOAD;
      ST_LOAD: begin
        tx_pop    = 1'b1;
        state_nxt = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (tx_busy)               state_nxt = ST_WAIT_DONE;
        else if (wait_cnt == 2'd3) state_nxt = ST_IDLE;
      end
      ST_WAIT_DONE: if (!tx_busy) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  assign tx_idle = tx_empty && (state == ST_IDLE);
  assign usr = {8'h00, 8'(rx_count), 8'(tx_count), 4'h0,
                overrun, tx_idle, !rx_empty, !tx_full};

  always_comb begin
    rdata_i = 32'h0;
    if (sel_ubrr)     rdata_i = {20'h0, ubrr};
    else if (sel_ucsz) rdata_i = {28'h0, ucsz};
    else if (sel_ucr)  rdata_i = {30'h0, ucr};
    else if (sel_udr)  rdata_i = rx_empty ? 32'h0 : {24'h0, rx_head};
    else if (sel_usr)  rdata_i = usr;
    else if (sel_ier)  rdata_i = {29'h0, ier};
  end

  assign bus.rdata = rdata_i;
endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Self-checking bench for uart_mmio_ctrl: scoreboard queues for TX and RX bytes,
// a simple transmitter busy model, one task per scenario.
module tb_uart_mmio_ctrl;
  localparam logic [31:0] BASE = 32'h40;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] ubrr;
  logic [3:0]  ucsz;
  logic [1:0]  ucr;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        irq;

  int total = 0;
  int bad = 0;
  int busy_cnt = 0;
  int tx_starts = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];

`ifdef UART_MMIO_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  uart_mmio_ctrl_if #(.ADDR_W(32)) bus ();

  uart_mmio_ctrl #(
    .BASE_ADDR(BASE), .ADDR_W(32), .TX_DEPTH(8), .RX_DEPTH(8), .UBRR_RST(12'd103)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .ubrr(ubrr), .ucsz(ucsz), .ucr(ucr),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .rx_data(rx_data), .rx_valid(rx_valid), .irq(irq)
  );

  always #5 clk = ~clk;

  assign tx_busy = (busy_cnt != 0);

  // Transmitter model: busy for 10 cycles after each start; checks bytes in order.
  initial begin
    logic [7:0] exp;
    forever begin
      @(negedge clk);
      if (!rst) busy_cnt = 0;
      else if (tx_start) begin
        tx_starts++;
        total++;
        if (tx_q.size() == 0) begin
          bad++;
          $display("[TB] FAIL tx_unexpected_start got=%h expected=none", tx_data);
        end else begin
          exp = tx_q.pop_front();
          if (tx_data !== exp) begin
            bad++;
            $display("[TB] FAIL tx_byte got=%h expected=%h", tx_data, exp);
          end
        end
        busy_cnt = 10;
      end else if (busy_cnt != 0) busy_cnt = busy_cnt - 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input int off, input logic [31:0] d);
    bus.addr  = BASE + 32'(off);
    bus.wdata = d;
    bus.we    = 1'b1;
    tick();
    bus.we    = 1'b0;
  endtask

  task automatic bus_read(input int off, output logic [31:0] d);
    bus.addr = BASE + 32'(off);
    bus.re   = 1'b1;
    #1;
    d = bus.rdata;
    tick();
    bus.re   = 1'b0;
  endtask

  task automatic wait_tx_idle(input string name);
    bit done = 1'b0;
    bus.addr = BASE + 32'd4;
    bus.re   = 1'b1;
    for (int i = 0; i < 400 && !done; i++) begin
      #1;
      if (bus.rdata[2] === 1'b1) done = 1'b1;
      else tick();
    end
    bus.re = 1'b0;
    total++;
    if (!done || tx_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL %s_drain idle=%0d left=%0d expected idle=1 left=0", name, done, tx_q.size());
    end
    tick();
  endtask

  task automatic test_reset();
    logic [31:0] d;
    bus.addr = '0; bus.wdata = '0; bus.we = 1'b0; bus.re = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    bus_write(0, 32'h5);
    bus_write(1, 32'h5);
    bus_write(2, 32'h3);
    bus_write(3, 32'h99);
    #2 rst = 1'b0;
    #1;
    total++;
    if (ubrr !== 12'd103 || ucsz !== 4'd8 || ucr !== 2'd0) begin
      bad++;
      $display("[TB] FAIL reset_regs got ubrr=%0d ucsz=%0d ucr=%0d expected 103 8 0", ubrr, ucsz, ucr);
    end
    total++;
    if (bus.stall !== 1'b0 || irq !== 1'b0 || tx_start !== 1'b0 || tx_data !== 8'h00) begin
      bad++;
      $display("[TB] FAIL reset_outs got stall=%b irq=%b start=%b data=%h expected 0 0 0 00",
               bus.stall, irq, tx_start, tx_data);
    end
    bus.addr = BASE + 32'd4;
    bus.re   = 1'b1;
    #1;
    d = bus.rdata;
    bus.re = 1'b0;
    total++;
    if (d !== 32'h0000_0005) begin
      bad++;
      $display("[TB] FAIL reset_usr got=%h expected=00000005", d);
    end
    tx_q.delete();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_regs();
    logic [31:0] d;
    bus_write(0, 32'hFFFF_FABC);
    bus_read(0, d);
    total++;
    if (d !== 32'h0000_0ABC || ubrr !== 12'hABC) begin
      bad++;
      $display("[TB] FAIL ubrr_rw got=%h port=%h expected=00000abc", d, ubrr);
    end
    bus_write(1, 32'h0000_00F7);
    bus_read(1, d);
    total++;
    if (d !== 32'h7 || ucsz !== 4'h7) begin
      bad++;
      $display("[TB] FAIL ucsz_rw got=%h expected=00000007", d);
    end
    bus_write(6, 32'hDEAD_BEEF);
    bus_read(6, d);
    total++;
    if (d !== 32'h0) begin
      bad++;
      $display("[TB] FAIL unmapped_read got=%h expected=00000000", d);
    end
    bus_read(-1, d);
    total++;
    if (d !== 32'h0) begin
      bad++;
      $display("[TB] FAIL below_base_read got=%h expected=00000000", d);
    end
    bus_write(5, 32'h5);
    bus_read(5, d);
    total++;
    if (d !== (IRQ_ON ? 32'h5 : 32'h0)) begin
      bad++;
      $display("[TB] FAIL ier_rw got=%h expected=%h", d, IRQ_ON ? 32'h5 : 32'h0);
    end
    bus_write(5, 32'h0);
  endtask

  task automatic test_tx_burst();
    int start0;
    bus_write(2, 32'h1);
    start0 = tx_starts;
    bus.addr = BASE + 32'd3;
    bus.we   = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.wdata = 32'h41 + 32'(i);
      #1;
      total++;
      if (bus.stall !== 1'b0) begin
        bad++;
        $display("[TB] FAIL burst_stall idx=%0d got=%b expected=0", i, bus.stall);
      end
      tx_q.push_back(8'(8'h41 + i));
      tick();
    end
    bus.we = 1'b0;
    wait_tx_idle("burst");
    total++;
    if (tx_starts - start0 != 8) begin
      bad++;
      $display("[TB] FAIL burst_starts got=%0d expected=8", tx_starts - start0);
    end
  endtask

  task automatic test_tx_full();
    logic [31:0] d;
    bit freed = 1'b0;
    bus_write(2, 32'h0);
    bus.addr = BASE + 32'd3;
    bus.we   = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.wdata = 32'h61 + 32'(i);
      tx_q.push_back(8'(8'h61 + i));
      tick();
    end
    bus.wdata = 32'h69;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (bus.stall !== 1'b1) begin
        bad++;
        $display("[TB] FAIL full_stall cyc=%0d got=%b expected=1", i, bus.stall);
      end
      tick();
    end
    bus.we = 1'b0;
    bus_write(2, 32'h1);
    bus.addr  = BASE + 32'd3;
    bus.wdata = 32'h69;
    bus.we    = 1'b1;
    for (int i = 0; i < 20 && !freed; i++) begin
      #1;
      if (bus.stall === 1'b0) freed = 1'b1;
      else tick();
    end
    total++;
    if (!freed) begin
      bad++;
      $display("[TB] FAIL full_release got stall=1 expected stall=0 within 20 cycles");
    end
    tx_q.push_back(8'h69);
    tick();
    bus.we = 1'b0;
    bus_read(4, d);
    total++;
    if (d[15:8] !== 8'd8) begin
      bad++;
      $display("[TB] FAIL full_txcount got=%0d expected=8", d[15:8]);
    end
    wait_tx_idle("full");
    bus_write(2, 32'h0);
  endtask

  task automatic test_rx_overrun();
    logic [31:0] d;
    logic [7:0] exp;
    bus_write(2, 32'h2);
    for (int i = 0; i < 9; i++) begin
      rx_valid = 1'b1;
      rx_data  = 8'(8'h10 + i);
      if (i < 8) rx_q.push_back(8'(8'h10 + i));
      tick();
    end
    rx_valid = 1'b0;
    bus_read(4, d);
    total++;
    if (d[3] !== 1'b1 || d[23:16] !== 8'd8) begin
      bad++;
      $display("[TB] FAIL ovr_status got ovr=%b cnt=%0d expected ovr=1 cnt=8", d[3], d[23:16]);
    end
    for (int i = 0; i < 8; i++) begin
      bus_read(3, d);
      exp = rx_q.pop_front();
      total++;
      if (d !== {24'h0, exp}) begin
        bad++;
        $display("[TB] FAIL ovr_read idx=%0d got=%h expected=%h", i, d, exp);
      end
    end
    bus_read(3, d);
    total++;
    if (d !== 32'h0) begin
      bad++;
      $display("[TB] FAIL empty_read got=%h expected=00000000", d);
    end
    bus_write(4, 32'h8);
    bus_read(4, d);
    total++;
    if (d[3] !== 1'b0 || d[1] !== 1'b0) begin
      bad++;
      $display("[TB] FAIL ovr_clear got ovr=%b nempty=%b expected 0 0", d[3], d[1]);
    end
  endtask

  task automatic test_rx_simultaneous();
    logic [31:0] d;
    logic [7:0] exp;
    for (int i = 0; i < 8; i++) begin
      rx_valid = 1'b1;
      rx_data  = 8'(8'h20 + i);
      rx_q.push_back(8'(8'h20 + i));
      tick();
    end
    rx_data  = 8'h55;
    bus.addr = BASE + 32'd3;
    bus.re   = 1'b1;
    #1;
    d   = bus.rdata;
    exp = rx_q.pop_front();
    rx_q.push_back(8'h55);
    tick();
    rx_valid = 1'b0;
    bus.re   = 1'b0;
    total++;
    if (d !== {24'h0, exp}) begin
      bad++;
      $display("[TB] FAIL simul_read got=%h expected=%h", d, exp);
    end
    bus_read(4, d);
    total++;
    if (d[23:16] !== 8'd8 || d[3] !== 1'b0) begin
      bad++;
      $display("[TB] FAIL simul_status got cnt=%0d ovr=%b expected cnt=8 ovr=0", d[23:16], d[3]);
    end
    for (int i = 0; i < 8; i++) begin
      bus_read(3, d);
      exp = rx_q.pop_front();
      total++;
      if (d !== {24'h0, exp}) begin
        bad++;
        $display("[TB] FAIL simul_drain idx=%0d got=%h expected=%h", i, d, exp);
      end
    end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    bus_write(5, 32'h1);
    bus_write(2, 32'h2);
    total++;
    if (irq !== 1'b0) begin
      bad++;
      $display("[TB] FAIL irq_idle got=%b expected=0", irq);
    end
    rx_valid = 1'b1;
    rx_data  = 8'h77;
    tick();
    rx_valid = 1'b0;
    total++;
    if (irq !== 1'b0) begin
      bad++;
      $display("[TB] FAIL irq_early got=%b expected=0", irq);
    end
    tick();
    total++;
    if (irq !== IRQ_ON) begin
      bad++;
      $display("[TB] FAIL irq_assert got=%b expected=%b", irq, IRQ_ON);
    end
    bus_read(3, d);
    total++;
    if (d !== 32'h77 || irq !== IRQ_ON) begin
      bad++;
      $display("[TB] FAIL irq_pop got data=%h irq=%b expected 00000077 %b", d, irq, IRQ_ON);
    end
    tick();
    total++;
    if (irq !== 1'b0) begin
      bad++;
      $display("[TB] FAIL irq_drop got=%b expected=0", irq);
    end
    bus_write(5, 32'h0);
  endtask

  initial begin
    test_reset();
    test_regs();
    test_tx_burst();
    test_tx_full();
    test_rx_overrun();
    test_rx_simultaneous();
    test_irq();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    bad++;
    $display("[TB] FAIL watchdog run exceeded time limit");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_mmio_ctrl.md
Name: uart_mmio_ctrl

Overview:
- Parametrised memory-mapped UART controller; next generation of the CPU/UART glue.
- Sits between the CPU data bus (beside data_mem) and the uart_top TX/RX engines.
- Replaces single-byte UDRT/UDRR registers with configurable-depth TX/RX FIFOs, a status register and a bus stall handshake.
- Adds sticky RX overrun detection.

Parameters:
- BASE_ADDR, 32'h40, word address of register 0; all registers at BASE_ADDR+offset.
- ADDR_W, 32, bus address width.
- TX_DEPTH, 8, TX FIFO entries; power of two, 2..128.
- RX_DEPTH, 8, RX FIFO entries; power of two, 2..128.
- UBRR_RST, 12'd103, reset value of UBRR.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- addr  in  ADDR_W  word address from ALU result.
- re  in  1  bus read strobe.
- we  in  1  bus write strobe.
- wdata  in  32  write data.
- rdata  out  32  read data; combinational; 0 when not selected.
- stall  out  1  hold CPU; PC and bus must stay frozen.
- ubrr  out  12  baud divisor to uart_top.
- ucsz  out  4  character size.
- ucr  out  2  [0] TX enable, [1] RX enable.
- tx_data  out  8  byte to transmitter.
- tx_start  out  1  one-cycle start pulse.
- tx_busy  in  1  transmitter busy.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle received-byte strobe.
- irq  out  1  interrupt request.

Behaviour:
- Register map, word offsets:
  - 0 UBRR, R/W [11:0]
  - 1 UCSZ, R/W [3:0]
  - 2 UCR, R/W [1:0]
  - 3 UDR: a write pushes wdata[7:0] to TX FIFO; a read returns RX head and pops it.
  - 4 USR, R
  - 5 IER, R/W [2:0]
- Unmapped offsets: reads return 0; writes are ignored.
- USR fields:
  - [0] TX not full
  - [1] RX not empty
  - [2] TX idle (FIFO empty and FSM IDLE)
  - [3] RX overrun, sticky; a write to USR with wdata[3]=1 clears it
  - [15:8] TX count
  - [23:16] RX count
- Reset (rst=0, asynchronous):
  - ubrr=UBRR_RST, ucsz=4'd8, ucr=0, IER=0.
  - Both FIFOs empty; overrun=0; FSM IDLE.
  - tx_start=0, stall=0, irq=0, tx_data=0.
- A reset mid-frame discards FIFO contents; uart_top is reset by the same rst.
- Register writes take effect on the rising edge while we=1 and stall=0.
- stall = we && UDR selected && TX full, combinational.
  - The push is not taken while stall=1, even if the FSM pops in the same cycle.
  - The push is accepted on the first edge with TX not full.
- UDR read with RX empty:
  - returns 0, no pop, no error; never stalls.
- UDR read pop happens on the rising edge while re=1.
- rx_valid handling:
  - ucr[1]=0: rx_valid is ignored.
  - RX full, rx_valid and a pop in the same cycle: both occur, count unchanged, no overrun.
  - RX full, rx_valid, no pop: byte dropped, overrun set.
- FIFO pointers wrap modulo depth; counts are one bit wider than the pointers.
- TX drain FSM:
  - IDLE: if ucr[0] && TX not empty && !tx_busy, move to LOAD.
  - LOAD: tx_data <= head; pop; tx_start=1 for exactly one cycle; move to WAIT_BUSY.
  - WAIT_BUSY: wait for tx_busy=1, then move to WAIT_DONE. Timeout after 4 cycles returns to IDLE.
  - WAIT_DONE: wait for tx_busy=0, then move to IDLE.
- Minimum byte spacing is 1 frame + 2 cycles.
- Clearing ucr[0] mid-frame finishes the current byte and holds the remaining FIFO contents.

Optional Feature:
- Macro UART_MMIO_IRQ_EN.
- Defined:
  - irq = (IER[0] & RX not empty) | (IER[1] & TX empty) | (IER[2] & overrun), registered one cycle.
- Undefined:
  - irq tied 0; IER reads 0 and writes are ignored.
  - All other behaviour is identical.

Decomposition:
- Package/header uart_mmio_regs.vh:
  - register offsets 0..5
  - USR bit indices
  - IER bit indices
  - FSM state encodings (2-bit)
  - reset constants for UCSZ and UCR
- Sub-module sync_fifo (parameters WIDTH, DEPTH):
  - ports: push, pop, din, dout, full, empty, count
  - instantiated for TX and RX
- The FSM and register decode stay in the top module.

Test Plan:
1. Reset: assert rst=0 mid-run -> ubrr=103, ucsz=8, ucr=0, USR=32'h0000_0005, stall=0, irq=0, all immediately, without a clock edge.
2. TX burst:
   - Stimulus: ucr=1, tx_busy model 10 cycles; write 0x41..0x48 to UDR back-to-back.
   - Response: no stall, eight tx_start pulses in order 0x41..0x48, then USR[2]=1.
3. TX full stall:
   - Stimulus: TX_DEPTH=8, ucr=0; write 9 bytes.
   - Response: stall=1 on the 9th write and held; setting ucr=1 drains one byte, after which the 9th push is accepted and stall=0.
4. RX overrun:
   - Stimulus: ucr=2; 9 rx_valid strobes 0x10..0x18, no reads.
   - Response: USR[3]=1, RX count=8, reads return 0x10..0x17, a 9th read returns 0.
   - Write USR 0x8 -> USR[3]=0.
5. RX simultaneous:
   - Stimulus: RX full, rx_valid(0x55) in the same cycle as a UDR read.
   - Response: read returns the oldest byte, count stays 8, no overrun, 0x55 is last out.
6. IRQ (UART_MMIO_IRQ_EN defined):
   - Stimulus: IER=1; one rx_valid.
   - Response: irq=1 one cycle after the push; reading UDR drops irq the cycle after the pop.
   - With the macro undefined, irq stays 0.
